// File: rtl/lsb_mem_agent_if.sv
// Bundle of the request, mem_ctrl bus and completion signals of the LSB memory agent.
// master = the agent itself, slave = the LSB / mem_ctrl side around it.
interface lsb_mem_agent_if #(
  parameter int ROB_WIDTH  = 4,
  parameter int ADDR_WIDTH = 32
);
  // request from the load/store buffer
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_is_store;
  logic [2:0]            req_funct3;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [31:0]           req_data;
  logic [ROB_WIDTH-1:0]  req_tag;
  // mem_ctrl port
  logic                  LSB_rn;
  logic                  LSB_wn;
  logic [ADDR_WIDTH-1:0] LSB_addr;
  logic [31:0]           LSB_Wvalue;
  logic [1:0]            LSB_len;
  logic                  LSB_ready;
  logic [31:0]           LSB_value;
  // tagged completion
  logic                  res_valid;
  logic                  res_is_store;
  logic [ROB_WIDTH-1:0]  res_tag;
  logic [31:0]           res_value;

  modport master (
    input  req_valid, req_is_store, req_funct3, req_addr, req_data, req_tag,
    output req_ready,
    output LSB_rn, LSB_wn, LSB_addr, LSB_Wvalue, LSB_len,
    input  LSB_ready, LSB_value,
    output res_valid, res_is_store, res_tag, res_value
  );

  modport slave (
    output req_valid, req_is_store, req_funct3, req_addr, req_data, req_tag,
    input  req_ready,
    input  LSB_rn, LSB_wn, LSB_addr, LSB_Wvalue, LSB_len,
    output LSB_ready, LSB_value,
    input  res_valid, res_is_store, res_tag, res_value
  );
endinterface

// File: rtl/lsb_mem_agent.sv
// LSB-side requester for mem_ctrl: one access in flight, load data extension,
// tagged completion, and flush handling that lets a killed load finish on the bus silently.
module lsb_mem_agent #(
  parameter int ROB_WIDTH  = 4,
  parameter int ADDR_WIDTH = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic rdy,
  input  logic clr,
  lsb_mem_agent_if.master bus
);

  typedef enum logic {IDLE, BUSY} state_e;

  state_e                state_q, state_d;
  logic                  drop_q, drop_d;
  logic                  rn_q, rn_d;
  logic                  wn_q, wn_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           wvalue_q, wvalue_d;
  logic [1:0]            len_q, len_d;
  logic                  is_store_q, is_store_d;
  logic [2:0]            funct3_q, funct3_d;
  logic [ROB_WIDTH-1:0]  tag_q, tag_d;
  logic                  res_valid_q, res_valid_d;
  logic                  res_is_store_q, res_is_store_d;
  logic [ROB_WIDTH-1:0]  res_tag_q, res_tag_d;
  logic [31:0]           res_value_q, res_value_d;

  logic        accept;
  logic [1:0]  req_len;
  logic [31:0] req_wvalue;
  logic [31:0] load_ext;

  assign bus.req_ready    = (state_q == IDLE) & rdy;
  assign bus.LSB_rn       = rn_q;
  assign bus.LSB_wn       = wn_q;
  assign bus.LSB_addr     = addr_q;
  assign bus.LSB_Wvalue   = wvalue_q;
  assign bus.LSB_len      = len_q;
  assign bus.res_valid    = res_valid_q;
  assign bus.res_is_store = res_is_store_q;
  assign bus.res_tag      = res_tag_q;
  assign bus.res_value    = res_value_q;

  // a load offered during a flush is younger than the mispredict and must not start
  assign accept = bus.req_valid & bus.req_ready & ~(clr & ~bus.req_is_store);

  // access width and masked store data for an incoming request
  always_comb begin
    req_len    = 2'd3;
    req_wvalue = bus.req_data;
    case (bus.req_funct3[1:0])
      2'b00: begin
        req_len    = 2'd0;
        req_wvalue = {24'b0, bus.req_data[7:0]};
      end
      2'b01: begin
        req_len    = 2'd1;
        req_wvalue = {16'b0, bus.req_data[15:0]};
      end
      default: ;
    endcase
  end

  // RV32I load extension of the raw little-endian read data
  always_comb begin
    load_ext = bus.LSB_value;
    case (funct3_q)
      3'b000:  load_ext = {{24{bus.LSB_value[7]}},  bus.LSB_value[7:0]};
      3'b001:  load_ext = {{16{bus.LSB_value[15]}}, bus.LSB_value[15:0]};
      3'b100:  load_ext = {24'b0, bus.LSB_value[7:0]};
      3'b101:  load_ext = {16'b0, bus.LSB_value[15:0]};
      default: ;
    endcase
  end

  // next-state: accept in IDLE, wait for LSB_ready in BUSY; everything holds while rdy is low
  always_comb begin
    state_d        = state_q;
    drop_d         = drop_q;
    rn_d           = rn_q;
    wn_d           = wn_q;
    addr_d         = addr_q;
    wvalue_d       = wvalue_q;
    len_d          = len_q;
    is_store_d     = is_store_q;
    funct3_d       = funct3_q;
    tag_d          = tag_q;
    res_valid_d    = res_valid_q;
    res_is_store_d = res_is_store_q;
    res_tag_d      = res_tag_q;
    res_value_d    = res_value_q;

    if (rdy) begin
      res_valid_d = 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            state_d    = BUSY;
            rn_d       = ~bus.req_is_store;
            wn_d       = bus.req_is_store;
            addr_d     = bus.req_addr;
            wvalue_d   = req_wvalue;
            len_d      = req_len;
            is_store_d = bus.req_is_store;
            funct3_d   = bus.req_funct3;
            tag_d      = bus.req_tag;
            drop_d     = 1'b0;
          end
        end
        BUSY: begin
          if (bus.LSB_ready) begin
            state_d = IDLE;
            rn_d    = 1'b0;
            wn_d    = 1'b0;
            drop_d  = 1'b0;
            // a load flushed earlier or on this very cycle completes silently
            if (is_store_q || !(drop_q || clr)) begin
              res_valid_d    = 1'b1;
              res_is_store_d = is_store_q;
              res_tag_d      = tag_q;
              res_value_d    = is_store_q ? 32'b0 : load_ext;
            end
          end else if (clr && !is_store_q) begin
            drop_d = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // state and output registers, synchronous reset abandons any access in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      drop_q         <= 1'b0;
      rn_q           <= 1'b0;
      wn_q           <= 1'b0;
      addr_q         <= '0;
      wvalue_q       <= '0;
      len_q          <= '0;
      is_store_q     <= 1'b0;
      funct3_q       <= '0;
      tag_q          <= '0;
      res_valid_q    <= 1'b0;
      res_is_store_q <= 1'b0;
      res_tag_q      <= '0;
      res_value_q    <= '0;
    end else begin
      state_q        <= state_d;
      drop_q         <= drop_d;
      rn_q           <= rn_d;
      wn_q           <= wn_d;
      addr_q         <= addr_d;
      wvalue_q       <= wvalue_d;
      len_q          <= len_d;
      is_store_q     <= is_store_d;
      funct3_q       <= funct3_d;
      tag_q          <= tag_d;
      res_valid_q    <= res_valid_d;
      res_is_store_q <= res_is_store_d;
      res_tag_q      <= res_tag_d;
      res_value_q    <= res_value_d;
    end
  end

endmodule

// File: tb/tb_lsb_mem_agent.sv
// Self-checking bench for lsb_mem_agent: directed vector table, hand-written corner
// sequences, and randomized transactions against a behavioural model.
module tb_lsb_mem_agent;
  localparam int RW = 4;
  localparam int AW = 32;

  logic clk = 1'b0;
  logic rst, rdy, clr;
  int   checks = 0;
  int   errors = 0;

  lsb_mem_agent_if #(.ROB_WIDTH(RW), .ADDR_WIDTH(AW)) bus ();

  lsb_mem_agent #(.ROB_WIDTH(RW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .clr(clr), .bus(bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog act=timeout req=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        st;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  tag;
    logic [31:0] rval;
    int          lat;
    int          clr_cyc;
    logic        clr_rdy;
    logic        clr_offer;
    logic [1:0]  e_len;
    logic [31:0] e_wval;
    logic        e_rv;
    logic [31:0] e_val;
  } vec_t;

  vec_t vecs[11];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h req=%h", nm, act, exp);
    end
  endtask

  // model: bytes touched by an access, from the low two funct3 bits
  function automatic int m_bytes(input logic [2:0] f3);
    if (f3[1:0] == 2'b00) return 1;
    if (f3[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  function automatic logic [31:0] m_wval(input logic [2:0] f3, input logic [31:0] d);
    longint m;
    m = (longint'(1) << (8 * m_bytes(f3))) - 1;
    return 32'(longint'(d) & m);
  endfunction

  function automatic logic [31:0] m_ext(input logic [2:0] f3, input logic [31:0] v);
    longint b;
    case (f3)
      3'd0: begin b = longint'(v) % 256;   if (b >= 128)   b = b - 256;   end
      3'd1: begin b = longint'(v) % 65536; if (b >= 32768) b = b - 65536; end
      3'd4: b = longint'(v) % 256;
      3'd5: b = longint'(v) % 65536;
      default: b = longint'(v);
    endcase
    return 32'(b);
  endfunction

  task automatic idle_inputs();
    bus.req_valid    = 1'b0;
    bus.req_is_store = 1'b0;
    bus.req_funct3   = 3'd0;
    bus.req_addr     = '0;
    bus.req_data     = '0;
    bus.req_tag      = '0;
    bus.LSB_ready    = 1'b0;
    bus.LSB_value    = '0;
    clr              = 1'b0;
  endtask

  // one full request: offer, hold through lat busy cycles, ready pulse, result check
  task automatic run_txn(input vec_t v);
    bus.req_valid    = 1'b1;
    bus.req_is_store = v.st;
    bus.req_funct3   = v.f3;
    bus.req_addr     = v.addr;
    bus.req_data     = v.data;
    bus.req_tag      = v.tag;
    clr              = v.clr_offer;
    chk("req_ready_idle", bus.req_ready, 1);
    step();
    bus.req_valid = 1'b0;
    clr           = 1'b0;
    chk("rn_issue", bus.LSB_rn, !v.st);
    chk("wn_issue", bus.LSB_wn, v.st);
    chk("addr", bus.LSB_addr, v.addr);
    chk("len", bus.LSB_len, v.e_len);
    if (v.st) chk("wvalue", bus.LSB_Wvalue, v.e_wval);
    for (int k = 0; k < v.lat; k++) begin
      clr = (k == v.clr_cyc);
      step();
      clr = 1'b0;
      chk("rn_hold", bus.LSB_rn, !v.st);
      chk("wn_hold", bus.LSB_wn, v.st);
      chk("busy_req_ready", bus.req_ready, 0);
      chk("busy_res_valid", bus.res_valid, 0);
    end
    bus.LSB_ready = 1'b1;
    bus.LSB_value = v.rval;
    clr           = v.clr_rdy;
    step();
    bus.LSB_ready = 1'b0;
    clr           = 1'b0;
    chk("rn_done", bus.LSB_rn, 0);
    chk("wn_done", bus.LSB_wn, 0);
    chk("req_ready_done", bus.req_ready, 1);
    chk("res_valid", bus.res_valid, v.e_rv);
    if (v.e_rv) begin
      chk("res_is_store", bus.res_is_store, v.st);
      chk("res_tag", bus.res_tag, v.tag);
      chk("res_value", bus.res_value, v.e_val);
    end
    step();
    chk("res_valid_pulse", bus.res_valid, 0);
  endtask

  function automatic vec_t mk(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] data, input logic [3:0] tag, input logic [31:0] rval,
                              input int lat, input int clr_cyc, input logic clr_rdy, input logic clr_offer,
                              input logic [1:0] e_len, input logic [31:0] e_wval, input logic e_rv,
                              input logic [31:0] e_val);
    vec_t v;
    v.st = st; v.f3 = f3; v.addr = addr; v.data = data; v.tag = tag; v.rval = rval;
    v.lat = lat; v.clr_cyc = clr_cyc; v.clr_rdy = clr_rdy; v.clr_offer = clr_offer;
    v.e_len = e_len; v.e_wval = e_wval; v.e_rv = e_rv; v.e_val = e_val;
    return v;
  endfunction

  initial begin
    vec_t rv;
    vecs[0]  = mk(0, 3'd0, 32'h100, 0, 4'd3, 32'h000000F0, 2, -1, 0, 0, 2'd0, 0, 1, 32'hFFFFFFF0);
    vecs[1]  = mk(0, 3'd4, 32'h100, 0, 4'd4, 32'h000000F0, 2, -1, 0, 0, 2'd0, 0, 1, 32'h000000F0);
    vecs[2]  = mk(1, 3'd1, 32'h200, 32'hDEADBEEF, 4'd6, 0, 1, -1, 0, 0, 2'd1, 32'h0000BEEF, 1, 0);
    vecs[3]  = mk(0, 3'd2, 32'h400, 0, 4'd7, 32'h12345678, 4, 1, 0, 0, 2'd3, 0, 0, 0);
    vecs[4]  = mk(1, 3'd0, 32'h010, 32'hA5A5A5C3, 4'd8, 0, 0, -1, 1, 1, 2'd0, 32'h000000C3, 1, 0);
    vecs[5]  = mk(0, 3'd1, 32'h020, 0, 4'd9, 32'h00008001, 0, -1, 0, 0, 2'd1, 0, 1, 32'hFFFF8001);
    vecs[6]  = mk(0, 3'd5, 32'h022, 0, 4'd10, 32'h7FFF8001, 1, -1, 0, 0, 2'd1, 0, 1, 32'h00008001);
    vecs[7]  = mk(0, 3'd2, 32'h040, 0, 4'd11, 32'h80000000, 2, -1, 1, 0, 2'd3, 0, 0, 0);
    vecs[8]  = mk(1, 3'd2, 32'h044, 32'h12345678, 4'd12, 0, 3, 0, 0, 0, 2'd3, 32'h12345678, 1, 0);
    vecs[9]  = mk(0, 3'd6, 32'h048, 0, 4'd13, 32'hCAFEF00D, 1, -1, 0, 0, 2'd3, 0, 1, 32'hCAFEF00D);
    vecs[10] = mk(0, 3'd0, 32'h04C, 0, 4'd14, 32'h1234567F, 0, -1, 0, 0, 2'd0, 0, 1, 32'h0000007F);

    idle_inputs();
    rdy = 1'b1;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    chk("rst_rn", bus.LSB_rn, 0);
    chk("rst_wn", bus.LSB_wn, 0);
    chk("rst_addr", bus.LSB_addr, 0);
    chk("rst_wvalue", bus.LSB_Wvalue, 0);
    chk("rst_len", bus.LSB_len, 0);
    chk("rst_res_valid", bus.res_valid, 0);
    chk("rst_res_tag", bus.res_tag, 0);
    chk("rst_res_value", bus.res_value, 0);
    chk("rst_req_ready", bus.req_ready, 1);

    // directed table
    foreach (vecs[i]) run_txn(vecs[i]);

    // a load offered with clr is refused
    bus.req_valid = 1'b1; bus.req_is_store = 1'b0; bus.req_funct3 = 3'd2;
    bus.req_addr = 32'h500; bus.req_tag = 4'd1; clr = 1'b1;
    step();
    idle_inputs();
    chk("clr_load_refused_rn", bus.LSB_rn, 0);
    chk("clr_load_refused_ready", bus.req_ready, 1);
    step();
    chk("clr_load_refused_rn2", bus.LSB_rn, 0);

    // rdy low in BUSY freezes everything, including an LSB_ready pulse
    bus.req_valid = 1'b1; bus.req_is_store = 1'b0; bus.req_funct3 = 3'd2;
    bus.req_addr = 32'h300; bus.req_tag = 4'd5;
    step();
    idle_inputs();
    chk("stall_rn", bus.LSB_rn, 1);
    rdy = 1'b0;
    #1;
    chk("stall_req_ready", bus.req_ready, 0);
    for (int k = 0; k < 3; k++) begin
      bus.LSB_ready = (k == 1);
      bus.LSB_value = 32'h11111111;
      step();
      bus.LSB_ready = 1'b0;
      chk("stall_rn_hold", bus.LSB_rn, 1);
      chk("stall_res_valid", bus.res_valid, 0);
    end
    rdy = 1'b1;
    step();
    chk("stall_rn_after", bus.LSB_rn, 1);
    bus.LSB_ready = 1'b1; bus.LSB_value = 32'h22223333;
    step();
    bus.LSB_ready = 1'b0;
    chk("stall_res_valid_done", bus.res_valid, 1);
    chk("stall_res_value", bus.res_value, 32'h22223333);
    chk("stall_res_tag", bus.res_tag, 5);
    // a new request accepted in the res_valid cycle
    bus.req_valid = 1'b1; bus.req_is_store = 1'b1; bus.req_funct3 = 3'd2;
    bus.req_addr = 32'h600; bus.req_data = 32'h0BADF00D; bus.req_tag = 4'd2;
    chk("b2b_req_ready", bus.req_ready, 1);
    step();
    idle_inputs();
    chk("b2b_wn", bus.LSB_wn, 1);
    chk("b2b_res_valid_low", bus.res_valid, 0);

    // reset mid-BUSY abandons the store
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_wn", bus.LSB_wn, 0);
    chk("midrst_addr", bus.LSB_addr, 0);
    chk("midrst_wvalue", bus.LSB_Wvalue, 0);
    chk("midrst_res_valid", bus.res_valid, 0);
    chk("midrst_res_value", bus.res_value, 0);
    chk("midrst_req_ready", bus.req_ready, 1);
    run_txn(mk(0, 3'd5, 32'h700, 0, 4'd15, 32'h00008001, 1, -1, 0, 0, 2'd1, 0, 1, 32'h00008001));

    // randomized transactions against the model
    for (int n = 0; n < 60; n++) begin
      logic [2:0] lf3[5];
      lf3[0] = 3'd0; lf3[1] = 3'd1; lf3[2] = 3'd2; lf3[3] = 3'd4; lf3[4] = 3'd5;
      rv.st        = 1'($urandom_range(0, 1));
      rv.f3        = rv.st ? 3'($urandom_range(0, 2)) : lf3[$urandom_range(0, 4)];
      rv.addr      = $urandom;
      rv.data      = $urandom;
      rv.tag       = 4'($urandom);
      rv.rval      = $urandom;
      rv.lat       = int'($urandom_range(0, 5));
      rv.clr_cyc   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 5)) : -1;
      rv.clr_rdy   = ($urandom_range(0, 5) == 0);
      rv.clr_offer = rv.st ? ($urandom_range(0, 3) == 0) : 1'b0;
      rv.e_len     = 2'(m_bytes(rv.f3) - 1);
      rv.e_wval    = m_wval(rv.f3, rv.data);
      rv.e_rv      = rv.st || !((rv.clr_cyc >= 0 && rv.clr_cyc < rv.lat) || rv.clr_rdy);
      rv.e_val     = rv.st ? 32'd0 : m_ext(rv.f3, rv.rval);
      run_txn(rv);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/lsb_mem_agent.md
Name: lsb_mem_agent

Overview:
- Requester side of the mem_ctrl LSB port, sitting between the load/store buffer and mem_ctrl.
- Accepts one committed-store or ready-load request at a time and drives LSB_rn/LSB_wn/LSB_addr/LSB_Wvalue/LSB_len until mem_ctrl pulses LSB_ready.
- Formats load data with RV32I sign/zero extension and returns a tagged completion to the LSB/CDB.
- Loads are flushable on misprediction; stores are not.

Parameters:
- ROB_WIDTH, 4, width of the request/result tag (ROB index).
- ADDR_WIDTH, 32, width of the memory address.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- rdy  input  1  global ready; all state frozen when low
- clr  input  1  misprediction flush
- req_valid  input  1  request offered
- req_ready  output  1  agent can accept a request this cycle
- req_is_store  input  1  1 = store, 0 = load
- req_funct3  input  3  RV32I funct3 of the access
- req_addr  input  ADDR_WIDTH  byte address (aligned by construction; not checked)
- req_data  input  32  store data (low bytes used)
- req_tag  input  ROB_WIDTH  ROB index
- LSB_rn  output  1  read request to mem_ctrl
- LSB_wn  output  1  write request to mem_ctrl
- LSB_addr  output  ADDR_WIDTH  access address
- LSB_Wvalue  output  32  store data, zero-masked to access width
- LSB_len  output  2  bytes-1: 0 = byte, 1 = half, 3 = word
- LSB_ready  input  1  one-cycle completion pulse from mem_ctrl
- LSB_value  input  32  raw read data, little-endian, valid while LSB_ready is high
- res_valid  output  1  one-cycle completion pulse
- res_is_store  output  1  completion belongs to a store
- res_tag  output  ROB_WIDTH  tag of the completed access
- res_value  output  32  extended load value; 0 for stores

Behaviour:
- Clock, reset and stall:
  - Single clock clk. rst is synchronous and active-high.
  - On rst: state=IDLE, LSB_rn=0, LSB_wn=0, LSB_addr=0, LSB_Wvalue=0, LSB_len=0, res_valid=0, res_is_store=0, res_tag=0, res_value=0, drop=0.
  - rst overrides rdy. Reset mid-transaction abandons the access with no result.
  - rdy=0: no register changes, outputs hold, req_ready is forced 0, and LSB_ready is ignored (mem_ctrl is frozen by the same rdy).
- States: IDLE, BUSY.
- req_ready = (state==IDLE) & rdy.
- Accept:
  - Occurs in IDLE when req_valid & req_ready & !(clr & !req_is_store).
  - A load offered in a clr cycle is refused. A store offered in a clr cycle is accepted.
  - On the accepting edge, register addr/len/Wvalue/tag/is_store/funct3; raise LSB_rn (load) or LSB_wn (store); go to BUSY.
  - Request lines become visible the cycle after acceptance.
- LSB_len from funct3[1:0]: 00→0, 01→1, 10→3.
- LSB_Wvalue: SB → {24'b0,d[7:0]}; SH → {16'b0,d[15:0]}; SW → d.
- BUSY:
  - All LSB_* outputs stay stable until LSB_ready.
  - On the LSB_ready cycle's edge: LSB_rn and LSB_wn drop to 0, state returns to IDLE, and exactly one mem_ctrl transaction occurs per request.
  - The result registers load on the same edge, so res_valid is high the cycle after LSB_ready, coincident with req_ready=1.
- Load extension of LSB_value v:
  - 000 LB → sext(v[7:0])
  - 001 LH → sext(v[15:0])
  - 010 LW → v
  - 100 LBU → zext(v[7:0])
  - 101 LHU → zext(v[15:0])
  - Other funct3 → v.
- Flush:
  - clr while a load is BUSY sets drop. The bus transaction still runs to LSB_ready and cannot be aborted.
  - On a dropped load's completion res_valid stays 0, drop clears, and the state returns to IDLE.
  - clr on the LSB_ready cycle of a load also suppresses its result.
  - clr never affects a BUSY store or its res_valid pulse.
  - clr during the res_valid cycle itself has no effect on that pulse; the consumer discards it.
- res_valid is high for exactly one cycle per completion. res_* hold their last values otherwise.
- Back-to-back: a new request may be accepted in the res_valid cycle. Minimum spacing between LSB_rn/LSB_wn assertions is one low cycle.

Test Plan:
- LB at 0x100 with mem_ctrl returning 0x000000F0 → LSB_rn=1, LSB_len=0 from cycle N+1 until ready. res_value=0xFFFFFFF0, res_tag correct, one-cycle res_valid. Repeat with LBU → 0x000000F0.
- SH addr 0x200, data 0xDEADBEEF → LSB_wn=1, LSB_len=1, LSB_Wvalue=0x0000BEEF. On ready: res_valid=1, res_is_store=1, res_value=0.
- LW issued, clr pulsed mid-BUSY, ready after 4 cycles → LSB_rn held until ready then dropped. No res_valid. req_ready returns 1.
- clr together with a load offer in IDLE → not accepted, LSB_rn stays 0. clr together with a store offer → accepted, completes normally.
- rdy low for 3 cycles during BUSY with LSB_ready pulsed while rdy=0 → no state change. A later LSB_ready with rdy=1 completes exactly once.
- rst asserted mid-BUSY → all outputs 0 next cycle, state IDLE. A following LHU of 0x8001 returns 0x00008001.
